// File: rtl/button_conditioner.sv
// Raw push-button front end: synchronize, debounce, auto-repeat, and arbitrate
// four buttons into one-hot single-cycle command pulses.

module button_lane #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 15000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic event_hit
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic          sync1, sync2, stable, stable_q;
    logic [DW-1:0] db_cnt;
    logic [RW-1:0] hold_cnt;
    logic [RW-1:0] rep_target;
    logic          rep_phase;
    logic          press, rep_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_q <= stable;
            if (sync2 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= ~stable;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    assign press = stable & ~stable_q;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; the counter
    // restarts at each hit so contention downstream never skews the cadence.
    assign rep_target = rep_phase ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
    assign rep_hit    = stable & ~press & (hold_cnt == rep_target);

    always_ff @(posedge clk) begin
        if (rst || !stable || press) begin
            hold_cnt  <= '0;
            rep_phase <= 1'b0;
        end else if (rep_hit) begin
            hold_cnt  <= '0;
            rep_phase <= 1'b1;
        end else begin
            hold_cnt  <= hold_cnt + RW'(1);
        end
    end

    assign level     = stable;
    assign event_hit = press | (REPEAT_EN & rep_hit);
endmodule

module button_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 250000,
    parameter int         REPEAT_DELAY    = 15000000,
    parameter int         REPEAT_PERIOD   = 5000000,
    parameter logic [3:0] REPEAT_MASK     = 4'b1001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    output logic [3:0] button,
    output logic [3:0] btn_level
);
    logic [3:0] events;
    logic [3:0] pending;
    logic [3:0] grant;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        button_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (REPEAT_MASK[i])
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .raw      (btn_raw[i]),
            .level    (btn_level[i]),
            .event_hit(events[i])
        );
    end

    // Lowest set bit wins; a fresh event on the granted bit re-arms it.
    assign grant = pending & (~pending + 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            button  <= '0;
        end else begin
            button  <= grant;
            pending <= (pending & ~grant) | events;
        end
    end
endmodule
